// File: rtl/bidir_shift_engine_if.sv
// Command/response bundle for bidir_shift_engine: valid/ready command port,
// serial input, and the register/serial/status outputs.
interface bidir_shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             ser_in;
  logic [WIDTH-1:0] out;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, ser_in,
    input  cmd_ready, out, ser_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, ser_in,
    output cmd_ready, out, ser_out, busy, done
  );
endinterface

// File: rtl/bidir_shift_engine.sv
// Universal WIDTH-bit shift register: parallel load plus logical/arithmetic
// shifts, rotates and serial-in shifts, applied one bit per clock.
module bidir_shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic                clk,
  input logic                rst,
  bidir_shift_engine_if.slave bus
);
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_SRA  = 3'b101;
  localparam logic [2:0] OP_SLS  = 3'b110;
  localparam logic [2:0] OP_SRS  = 3'b111;
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_out;
  logic             r_ser_out;
  logic             r_done;

  logic             w_accept;
  logic [AMT_W-1:0] w_amt;
  logic [WIDTH:0]   w_step;

  // One step of the latched op; result is {bit shifted out, next register value}.
  function automatic logic [WIDTH:0] step_fn(input logic [2:0] op,
                                             input logic [WIDTH-1:0] cur,
                                             input logic sin,
                                             input logic cur_ser);
    logic [WIDTH:0] res;
    case (op)
      OP_SLL:  res = {cur[WIDTH-1], cur[WIDTH-2:0], 1'b0};
      OP_SRL:  res = {cur[0], 1'b0, cur[WIDTH-1:1]};
      OP_ROL:  res = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:  res = {cur[0], cur[0], cur[WIDTH-1:1]};
      OP_SRA:  res = {cur[0], cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_SLS:  res = {cur[WIDTH-1], cur[WIDTH-2:0], sin};
      OP_SRS:  res = {cur[0], sin, cur[WIDTH-1:1]};
      default: res = {cur_ser, cur};
    endcase
    return res;
  endfunction

  assign w_accept = bus.cmd_valid && bus.cmd_ready;

  // Clamp the requested step count and compute the next shift step.
  always_comb begin
    w_amt  = bus.cmd_amt;
    w_step = step_fn(r_op, r_out, bus.ser_in, r_ser_out);
    if (bus.cmd_amt > AMT_MAX) begin
      w_amt = AMT_MAX;
    end else begin
      w_amt = bus.cmd_amt;
    end
  end

  // Command FSM and datapath registers; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_LOAD;
      r_rem     <= '0;
      r_out     <= '0;
      r_ser_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.cmd_op == OP_LOAD) begin
              r_out  <= bus.cmd_data;
              r_done <= 1'b1;
            end else if (w_amt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_op    <= bus.cmd_op;
              r_rem   <= w_amt;
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          {r_ser_out, r_out} <= w_step;
          r_rem              <= r_rem - AMT_W'(1);
          if (r_rem == AMT_W'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE) && !rst;
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.out       = r_out;
  assign bus.ser_out   = r_ser_out;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_bidir_shift_engine.sv
// Scoreboard bench for bidir_shift_engine (WIDTH=8): the driver queues the
// expected done-cycle values, a monitor pops and compares on every done pulse.
module tb_bidir_shift_engine;
  localparam logic [2:0] LOAD = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SRL  = 3'b010;
  localparam logic [2:0] ROL  = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] SRA  = 3'b101;
  localparam logic [2:0] SRS  = 3'b111;

  typedef struct packed {
    logic [7:0] out;
    logic       ser;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t done_q[$];
  exp_t step_q[$];

  bidir_shift_engine_if #(.WIDTH(8)) bus ();

  bidir_shift_engine #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 8'h%02h, want 8'h%02h", name, got, want);
    end
  endtask

  // Monitor: per-step trace checks (when queued) and done-cycle scoreboard.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_busy && step_q.size() != 0) begin
        e = step_q.pop_front();
        check("step_out", bus.out, e.out);
        check("step_ser", {7'd0, bus.ser_out}, {7'd0, e.ser});
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 out=8'h%02h, want no done", bus.out);
        end else begin
          e = done_q.pop_front();
          check("done_out", bus.out, e.out);
          check("done_ser", {7'd0, bus.ser_out}, {7'd0, e.ser});
        end
      end
      prev_busy = bus.busy;
    end
  end

  // Present a command at a negedge and hold it until it is accepted.
  task automatic send(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] data,
                      output int waited, output logic in_done);
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    waited  = 0;
    in_done = 1'b0;
    while (!bus.cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no cmd_ready in 40 cycles, want acceptance");
      bus.cmd_valid = 1'b0;
    end else begin
      in_done = bus.done;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] data,
                     input logic [7:0] exp_out, input logic exp_ser);
    int   w;
    logic d;
    done_q.push_back('{out: exp_out, ser: exp_ser});
    send(op, amt, data, w, d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || done_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d, want idle", bus.busy, done_q.size());
    end
  endtask

  initial begin
    int         w;
    int         nbusy;
    logic       d;
    logic [7:0] bits;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = LOAD;
    bus.cmd_amt   = 4'd0;
    bus.cmd_data  = 8'h00;
    bus.ser_in    = 1'b0;

    // 1: reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready_low", {7'd0, bus.cmd_ready}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out", bus.out, 8'h00);
    check("rst_ser", {7'd0, bus.ser_out}, 8'h00);
    check("rst_busy", {7'd0, bus.busy}, 8'h00);
    check("rst_done", {7'd0, bus.done}, 8'h00);
    check("rst_ready", {7'd0, bus.cmd_ready}, 8'h01);

    // 2: LOAD then SLL 3 issued back-to-back in the done cycle
    cmd(LOAD, 4'd0, 8'h96, 8'h96, 1'b0);
    step_q.push_back('{out: 8'h2C, ser: 1'b1});
    step_q.push_back('{out: 8'h58, ser: 1'b0});
    step_q.push_back('{out: 8'hB0, ser: 1'b0});
    cmd(SLL, 4'd3, 8'h00, 8'hB0, 1'b0);
    nbusy = 0;
    while (bus.busy && nbusy < 20) begin
      nbusy++;
      @(negedge clk);
    end
    check("sll_busy_cycles", 8'(nbusy), 8'd3);
    wait_idle();
    check("step_q_drained", 8'(step_q.size()), 8'd0);

    // 3: ROR, SRA, zero-amount shift
    cmd(ROR, 4'd4, 8'h00, 8'h0B, 1'b0);
    wait_idle();
    cmd(LOAD, 4'd0, 8'hB0, 8'hB0, 1'b0);
    cmd(SRA, 4'd2, 8'h00, 8'hEC, 1'b0);
    wait_idle();
    cmd(SRL, 4'd0, 8'h00, 8'hEC, 1'b0);
    check("amt0_done_next", {7'd0, bus.done}, 8'h01);
    wait_idle();

    // 4: SRS with serial bits applied one per step
    cmd(LOAD, 4'd0, 8'h00, 8'h00, 1'b0);
    cmd(SRS, 4'd8, 8'h00, 8'h53, 1'b0);
    bits = 8'b0101_0011;
    for (int i = 0; i < 8; i++) begin
      bus.ser_in = bits[i];
      @(negedge clk);
    end
    bus.ser_in = 1'b0;
    wait_idle();

    // 5: clamp plus a LOAD held during busy
    cmd(LOAD, 4'd0, 8'hFF, 8'hFF, 1'b0);
    cmd(SLL, 4'd12, 8'h00, 8'h00, 1'b1);
    done_q.push_back('{out: 8'hAA, ser: 1'b1});
    send(LOAD, 4'd0, 8'hAA, w, d);
    check("held_wait_cycles", 8'(w), 8'd8);
    check("held_in_done", {7'd0, d}, 8'h01);
    wait_idle();
    check("held_out", bus.out, 8'hAA);

    // 6: reset in the middle of a rotate
    cmd(LOAD, 4'd0, 8'hF0, 8'hF0, 1'b1);
    send(ROL, 4'd6, 8'h00, w, d);
    repeat (2) @(negedge clk);
    check("rol_mid_out", bus.out, 8'hC3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out", bus.out, 8'h00);
    check("abort_busy", {7'd0, bus.busy}, 8'h00);
    check("abort_ready", {7'd0, bus.cmd_ready}, 8'h01);
    check("abort_ser", {7'd0, bus.ser_out}, 8'h00);
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end
endmodule
